// File: rtl/huffman_stream_scheduler_pkg.sv
// Shared definitions for the Huffman stream scheduler.
// Holds the default widths, the FSM state type and a small width helper.
package huffman_stream_scheduler_pkg;

  // Huffman code length of the decoder; one extra bit carries the flag.
  localparam int K_BITS            = 4;
  localparam int NUM_REQ_DEF       = 4;
  localparam int IN_WORD_WIDTH_DEF = K_BITS + 1;
  localparam int CNT_WIDTH_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Requester index width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/huffman_stream_scheduler_if.sv
// Handshake bundle between the compressed-stream requesters, the scheduler
// and the Huffman decoder.
//   s_data/s_valid/s_last/s_ready : per-requester input streams
//   m_data/m_valid/m_last/m_id    : merged stream towards the decoder
//   m_ready                       : decoder input ready
//   dec_idle                      : decoder shift buffer empty
// The slave modport is the scheduler's view, master is the environment's.
interface huffman_stream_scheduler_if
  import huffman_stream_scheduler_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEF,
  parameter int IN_WORD_WIDTH = IN_WORD_WIDTH_DEF,
  parameter int ID_WIDTH      = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0][IN_WORD_WIDTH-1:0] s_data;
  logic [NUM_REQ-1:0]                    s_valid;
  logic [NUM_REQ-1:0]                    s_last;
  logic [NUM_REQ-1:0]                    s_ready;
  logic [IN_WORD_WIDTH-1:0]              m_data;
  logic                                  m_valid;
  logic                                  m_last;
  logic [ID_WIDTH-1:0]                   m_id;
  logic                                  m_ready;
  logic                                  dec_idle;

  modport slave (
    input  s_data, s_valid, s_last, m_ready, dec_idle,
    output s_ready, m_data, m_valid, m_last, m_id
  );

  modport master (
    output s_data, s_valid, s_last, m_ready, dec_idle,
    input  s_ready, m_data, m_valid, m_last, m_id
  );

endinterface

// File: rtl/huffman_stream_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_grant : index served most recently; search starts one above it
//   grant      : first requesting index found (wrapping modulo NUM_REQ)
//   any_req    : at least one request present
module rr_arbiter
  import huffman_stream_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [ID_WIDTH-1:0] grant,
  output logic                any_req
);

  logic found;

  // Scan from last_grant+1 upward, wrapping, so last_grant itself is checked last.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    any_req = |req;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant = ID_WIDTH'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/huffman_stream_scheduler.sv
// Shares one Huffman decoder among NUM_REQ compressed-stream requesters.
// A requester is picked round-robin, keeps the decoder for a whole frame,
// and the next frame only starts once the decoder buffer has drained.
//   clk, rst    : clock and asynchronous active-high reset
//   bus         : stream handshakes (slave modport of the interface)
//   frame_done  : one-cycle pulse after the last word of a frame is accepted
//   frame_words : saturating word count of the most recent frame
//   busy        : scheduler is not idle
module huffman_stream_scheduler
  import huffman_stream_scheduler_pkg::*;
#(
  parameter int  NUM_REQ       = NUM_REQ_DEF,
  parameter int  IN_WORD_WIDTH = IN_WORD_WIDTH_DEF,
  parameter int  CNT_WIDTH     = CNT_WIDTH_DEF,
  localparam int ID_WIDTH      = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  huffman_stream_scheduler_if.slave     bus,
  output logic                          frame_done,
  output logic [CNT_WIDTH-1:0]          frame_words,
  output logic                          busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   last_grant;
  logic [ID_WIDTH-1:0]   arb_grant;
  logic                  any_req;
  logic [CNT_WIDTH-1:0]  counter;
  logic [CNT_WIDTH-1:0]  count_next;
  logic [NUM_REQ-1:0]    ready_vec;
  logic                  xfer;
  logic                  hs;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req        (bus.s_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  assign xfer = (state == XFER);
  assign hs   = xfer & bus.s_valid[grant] & bus.m_ready;

  // Next word count, pinned at the all-ones value for over-long frames.
  always_comb begin
    if (counter == CNT_MAX) begin
      count_next = CNT_MAX;
    end else begin
      count_next = counter + CNT_WIDTH'(1);
    end
  end

  // Pass the granted stream straight through; everything is closed outside XFER.
  always_comb begin
    ready_vec   = '0;
    bus.m_data  = '0;
    bus.m_valid = 1'b0;
    bus.m_last  = 1'b0;
    if (xfer) begin
      ready_vec[grant] = bus.m_ready;
      bus.m_data       = bus.s_data[grant];
      bus.m_valid      = bus.s_valid[grant];
      bus.m_last       = bus.s_last[grant];
    end else begin
      ready_vec = '0;
    end
  end

  assign bus.s_ready = ready_vec;
  assign bus.m_id    = grant;

  // Scheduler FSM with its registered status outputs and frame word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= ID_WIDTH'(NUM_REQ - 1);
      counter     <= '0;
      frame_words <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= arb_grant;
            counter <= '0;
            busy    <= 1'b1;
            state   <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          state <= XFER;
        end
        XFER: begin
          // A dropped s_valid just stalls the frame; the grant is kept.
          if (hs) begin
            counter <= count_next;
            if (bus.s_last[grant]) begin
              frame_words <= count_next;
              frame_done  <= 1'b1;
              last_grant  <= grant;
              state       <= DRAIN;
            end else begin
              state <= XFER;
            end
          end else begin
            state <= XFER;
          end
        end
        DRAIN: begin
          // Wait until the decoder has consumed every buffered bit.
          if (bus.dec_idle) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= DRAIN;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_stream_scheduler.sv
// Directed bench for huffman_stream_scheduler: a table of per-cycle vectors
// for arbitration order, plus hand-written multi-cycle sequences.
module tb_huffman_stream_scheduler;
  import huffman_stream_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  huffman_stream_scheduler_if #(.NUM_REQ(4), .IN_WORD_WIDTH(5), .ID_WIDTH(2)) bus ();
  huffman_stream_scheduler_if #(.NUM_REQ(4), .IN_WORD_WIDTH(5), .ID_WIDTH(2)) bus4 ();

  logic        fd, fd4;
  logic [15:0] fw;
  logic [3:0]  fw4;
  logic        busy, busy4;

  huffman_stream_scheduler u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .frame_done  (fd),
    .frame_words (fw),
    .busy        (busy)
  );

  huffman_stream_scheduler #(.CNT_WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus4.slave),
    .frame_done  (fd4),
    .frame_words (fw4),
    .busy        (busy4)
  );

  typedef struct {
    logic [3:0]  sv;
    logic [3:0]  sl;
    logic        mr;
    logic        di;
    logic        exp_busy;
    logic [3:0]  exp_rdy;
    logic        exp_mv;
    logic        exp_ml;
    logic [4:0]  exp_md;
    logic [1:0]  exp_mid;
    logic        exp_fd;
    logic [15:0] exp_fw;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic [30:0] act_v, exp_v;
  int beat, fd_cnt, side_err, frames, cur_id, ilv_err;
  int order [8];
  logic [3:0] fw4_cap;

  initial begin
    // cycle-by-cycle: requesters 0 and 2 together after reset
    tbl[0]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0, 16'd0};
    tbl[1]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0, 16'd0};
    tbl[2]  = '{4'b0101, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 5'h08, 2'd0, 1'b0, 16'd0};
    tbl[3]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'h00, 2'd0, 1'b1, 16'd1};
    tbl[4]  = '{4'b0101, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0, 16'd1};
    tbl[5]  = '{4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0, 16'd1};
    tbl[6]  = '{4'b0101, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0, 16'd1};
    tbl[7]  = '{4'b0101, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 5'h0A, 2'd2, 1'b0, 16'd1};
    tbl[8]  = '{4'b0101, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 5'h0A, 2'd2, 1'b0, 16'd1};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 5'h00, 2'd0, 1'b1, 16'd1};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 5'h00, 2'd0, 1'b0, 16'd1};

    rst = 1'b1;
    bus.s_data = '0;  bus.s_valid = '0;  bus.s_last = '0;  bus.m_ready = 1'b0;  bus.dec_idle = 1'b0;
    bus4.s_data = '0; bus4.s_valid = '0; bus4.s_last = '0; bus4.m_ready = 1'b0; bus4.dec_idle = 1'b0;
    #2;
    check("reset_outputs", {busy, bus.s_ready, bus.m_valid, fd, fw}, 64'd0);
    check("reset_outputs_cnt4", {busy4, bus4.s_ready, bus4.m_valid, fd4, fw4}, 64'd0);
    adv();
    rst = 1'b0;

    // ---- table: arbitration order, GRANT latency, m_ready gating
    bus.s_data = {5'h0B, 5'h0A, 5'h09, 5'h08};
    for (int i = 0; i < 11; i++) begin
      bus.s_valid  = tbl[i].sv;
      bus.s_last   = tbl[i].sl;
      bus.m_ready  = tbl[i].mr;
      bus.dec_idle = tbl[i].di;
      @(negedge clk);
      act_v = {busy, bus.s_ready, bus.m_valid,
               tbl[i].exp_mv ? bus.m_last : 1'b0,
               tbl[i].exp_mv ? bus.m_data : 5'h00,
               tbl[i].exp_mv ? bus.m_id   : 2'd0, fd, fw};
      exp_v = {tbl[i].exp_busy, tbl[i].exp_rdy, tbl[i].exp_mv, tbl[i].exp_ml,
               tbl[i].exp_md, tbl[i].exp_mid, tbl[i].exp_fd, tbl[i].exp_fw};
      check($sformatf("table_step%0d", i), 64'(act_v), 64'(exp_v));
      adv();
    end

    // ---- 5-word frame on requester 1, m_ready toggling, valid dropped once
    bus.s_valid = 4'b0010; bus.s_last = 4'b0000; bus.m_ready = 1'b0; bus.dec_idle = 1'b1;
    adv();
    bus.s_valid = 4'b1011;
    @(negedge clk);
    check("grant_cycle_closed", {busy, bus.m_valid, bus.s_ready}, {58'd0, 1'b1, 1'b0, 4'b0000});
    adv();
    beat = 0; fd_cnt = 0; side_err = 0;
    for (int c = 0; c < 16; c++) begin
      bus.m_ready    = (c % 2 == 0);
      bus.s_last     = (beat == 4) ? 4'b0010 : 4'b0000;
      bus.s_data[1]  = 5'h10 + 5'(beat);
      bus.s_valid    = (beat < 5) ? {1'b1, 1'b0, (c != 2), 1'b1} : 4'b0000;
      @(negedge clk);
      if (fd) fd_cnt++;
      if ((bus.s_ready & 4'b1101) != 4'b0000) side_err++;
      if (bus.m_valid && bus.m_ready) begin
        check($sformatf("r1_beat%0d_id", beat), 64'(bus.m_id), 64'd1);
        check($sformatf("r1_beat%0d_last", beat), 64'(bus.m_last), 64'(beat == 4));
        check($sformatf("r1_beat%0d_data", beat), 64'(bus.m_data), 64'(5'h10 + 5'(beat)));
        beat++;
      end
      adv();
    end
    check("r1_handshakes", 64'(beat), 64'd5);
    check("r1_frame_done_pulses", 64'(fd_cnt), 64'd1);
    check("r1_frame_words", 64'(fw), 64'd5);
    check("r1_other_ready_low", 64'(side_err), 64'd0);
    check("r1_back_idle", 64'(busy), 64'd0);

    // ---- reset in the middle of a frame from requester 2
    bus.s_valid = 4'b0100; bus.s_last = 4'b0000; bus.m_ready = 1'b1; bus.dec_idle = 1'b1;
    bus.s_data[2] = 5'h0A;
    adv();
    adv();
    @(negedge clk);
    check("pre_reset_xfer", {bus.m_valid, bus.m_id}, {61'd0, 1'b1, 2'd2});
    adv();
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_xfer", {busy, bus.s_ready, bus.m_valid, fd}, 64'd0);
    adv();
    rst = 1'b0;
    bus.s_valid = 4'b0110; bus.s_last = 4'b0110;
    @(negedge clk);
    check("post_reset_idle", {busy, fd}, 64'd0);
    adv();
    adv();
    @(negedge clk);
    check("post_reset_first_grant", {bus.m_valid, bus.m_last, bus.m_id}, {60'd0, 1'b1, 1'b1, 2'd1});
    adv();
    bus.s_valid = 4'b0000; bus.s_last = 4'b0000;
    @(negedge clk);
    check("post_reset_frame_done", {fd, fw}, {47'd0, 1'b1, 16'd1});
    adv();

    // ---- single-word frame on requester 3, decoder idle arrives 4 cycles late
    bus.s_valid = 4'b1000; bus.s_last = 4'b1000; bus.m_ready = 1'b1; bus.dec_idle = 1'b0;
    adv();
    adv();
    @(negedge clk);
    check("r3_xfer", {bus.m_valid, bus.m_last, bus.m_id}, {60'd0, 1'b1, 1'b1, 2'd3});
    adv();
    bus.s_valid = 4'b0000; bus.s_last = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("r3_drain_hold%0d", k), {busy, bus.m_valid, fd}, {61'd0, 1'b1, 1'b0, (k == 0)});
      adv();
    end
    bus.dec_idle = 1'b1;
    @(negedge clk);
    check("r3_drain_last", {busy, fw}, {47'd0, 1'b1, 16'd1});
    adv();
    bus.dec_idle = 1'b0;
    @(negedge clk);
    check("r3_drain_exit", 64'(busy), 64'd0);
    adv();

    // ---- all four requesters valid, 8 two-word frames
    bus.s_valid = 4'b1111; bus.m_ready = 1'b1; bus.dec_idle = 1'b1;
    beat = 0; frames = 0; cur_id = 0; ilv_err = 0;
    for (int c = 0; c < 200 && frames < 8; c++) begin
      bus.s_last = (beat == 1) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        if (beat == 0) begin
          order[frames] = int'(bus.m_id);
          cur_id = int'(bus.m_id);
          beat = 1;
        end else begin
          if (int'(bus.m_id) != cur_id) ilv_err++;
          frames++;
          beat = 0;
        end
      end
      adv();
    end
    bus.s_valid = 4'b0000; bus.s_last = 4'b0000;
    check("rr_frames_done", 64'(frames), 64'd8);
    check("rr_no_interleave", 64'(ilv_err), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i % 4));
    end
    adv();
    adv();

    // ---- 20-word frame on the 4-bit counter instance
    bus4.s_valid = 4'b0001; bus4.m_ready = 1'b1; bus4.dec_idle = 1'b1;
    beat = 0; fd_cnt = 0; fw4_cap = 4'd0;
    for (int c = 0; c < 60; c++) begin
      bus4.s_last    = (beat == 19) ? 4'b0001 : 4'b0000;
      bus4.s_valid   = (beat < 20) ? 4'b0001 : 4'b0000;
      bus4.s_data[0] = 5'(beat);
      @(negedge clk);
      if (fd4) begin
        fd_cnt++;
        fw4_cap = fw4;
      end
      if (bus4.m_valid && bus4.m_ready) beat++;
      adv();
    end
    check("sat_handshakes", 64'(beat), 64'd20);
    check("sat_frame_done_pulses", 64'(fd_cnt), 64'd1);
    check("sat_frame_words", 64'(fw4_cap), 64'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/huffman_stream_scheduler.md
HUFFMAN_STREAM_SCHEDULER -- requirements
Module: huffman_stream_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of compressed-stream requesters sharing one Huffman decoder.
REQ-002 SHALL have parameter IN_WORD_WIDTH, default K_BITS+1 (5): compressed word width, including the flag bit.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the per-frame word counter.
REQ-004 SHALL have derived parameter ID_WIDTH = max(1, $clog2(NUM_REQ)).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port s_data, input, NUM_REQ x IN_WORD_WIDTH: per-requester compressed words.
REQ-008 SHALL have ports s_valid / s_last, input, NUM_REQ each: per-requester valid and end-of-frame.
REQ-009 SHALL have port s_ready, output, NUM_REQ: per-requester ready.
REQ-010 SHALL have ports m_data (IN_WORD_WIDTH), m_valid, m_last, m_id (ID_WIDTH), output: stream to the decoder.
REQ-011 SHALL have port m_ready, input, 1: decoder input ready.
REQ-012 SHALL have port dec_idle, input, 1: decoder buffer empty (shift counter zero).
REQ-013 SHALL have ports frame_done (1) and frame_words (CNT_WIDTH), output: end-of-frame pulse and the accepted word count.
REQ-014 SHALL have port busy, output, 1: high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, XFER and DRAIN.
REQ-016 In IDLE, if any s_valid is high, SHALL select a requester round-robin, starting at last_grant+1 modulo NUM_REQ, register it as grant, and move to GRANT.
REQ-017 SHALL spend exactly one cycle in GRANT with all s_ready=0 and m_valid=0, then move to XFER (arbitration latency is 2 cycles from s_valid).
REQ-018 In XFER, SHALL pass through combinationally: m_data=s_data[grant], m_valid=s_valid[grant], m_last=s_last[grant], s_ready[grant]=m_ready, all other s_ready=0, m_id=grant.
REQ-019 SHALL hold the grant for the whole frame; a granted requester dropping s_valid mid-frame SHALL NOT release the grant (no preemption).
REQ-020 On an XFER handshake with s_last high, SHALL update last_grant=grant and move to DRAIN.
REQ-021 In DRAIN, SHALL hold all s_ready=0 and m_valid=0, and SHALL return to IDLE on the first cycle in which dec_idle=1; dec_idle already high on entry SHALL exit after one DRAIN cycle.
REQ-022 The word counter SHALL increment on each XFER handshake, saturate at 2^CNT_WIDTH-1, and clear on entry to GRANT.
REQ-023 On the last-word handshake, SHALL register frame_words = counter+1 (saturating) and pulse frame_done for exactly one cycle.
REQ-024 A single-word frame (s_last on the first beat) SHALL give frame_words=1.
REQ-025 Outside XFER, SHALL drive all s_ready=0 and m_valid=0 regardless of m_ready.
REQ-026 Non-granted s_valid SHALL be ignored until the next return to IDLE; frames from different requesters SHALL never interleave at m_*.

Reset
REQ-027 On rst high, SHALL immediately set state=IDLE, grant=0, last_grant=NUM_REQ-1, counter=0, frame_words=0, frame_done=0, busy=0, m_valid=0 and all s_ready=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no frame_done; the first post-reset grant SHALL go to the lowest-index requester with s_valid high.

Structure
REQ-029 NUM_REQ, IN_WORD_WIDTH, CNT_WIDTH defaults and the FSM state enum typedef SHALL live in the shared package.
REQ-030 The round-robin selection SHALL be a sub-module rr_arbiter (inputs: req vector, last_grant; outputs: grant index, any_req), purely combinational.

Verification
REQ-031 rst mid-XFER -> next cycle state IDLE, all s_ready=0, m_valid=0, no frame_done.
REQ-032 Requesters 0 and 2 valid together after reset -> requester 0 served first; after its DRAIN, requester 2; m_id=0 then 2.
REQ-033 Requester 1 sends a 5-word frame while m_ready toggles 1,0,1,0 -> 5 handshakes, frame_words=5, a single frame_done pulse, m_last only on word 5.
REQ-034 Single-word frame on requester 3 -> frame_words=1; DRAIN held until dec_idle=1 injected 4 cycles later, then IDLE.
REQ-035 All four requesters continuously valid for 8 frames -> grant order 0,1,2,3,0,1,2,3 with no interleaving at m_*.
REQ-036 Frame longer than 2^CNT_WIDTH-1 words (CNT_WIDTH=4, 20 words) -> frame_words=15.
